// File: rtl/effect_frame_scheduler.sv
// Per-sample sequencer: captures an ADC sample, starts the enabled effect channels,
// gathers their done pulses (with timeout) and hands one data-valid to the mixer.
module effect_frame_scheduler #(
  parameter int data_width     = 16,
  parameter int timeout_cycles = 1023,
  parameter int cnt_width      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            i_sw,
  input  logic                  i_clear_stats,
  input  logic                  i_sample_valid,
  input  logic [data_width-1:0] i_sample,
  input  logic                  i_fifo_full,
  output logic [data_width-1:0] o_sample_to_eff,
  output logic                  o_start_eff0,
  output logic                  o_start_eff1,
  input  logic                  i_done_eff0,
  input  logic                  i_done_eff1,
  input  logic                  i_mixer_ready,
  input  logic                  i_mixer_read_done,
  output logic                  o_dv_to_mixer,
  output logic [1:0]            o_sw_to_mixer,
  output logic                  o_busy,
  output logic                  o_overrun,
  output logic [cnt_width-1:0]  o_drop_count,
  output logic [cnt_width-1:0]  o_timeout_count
);

  localparam int TW = $clog2(timeout_cycles + 1);
  // Timer counts cycles already spent in the wait state; the last allowed one forces advance.
  localparam logic [TW-1:0]        TLAST = TW'(timeout_cycles - 1);
  localparam logic [cnt_width-1:0] CMAX  = '1;

  typedef enum logic [2:0] {IDLE, DISPATCH, WAIT_EFF, HANDOFF, WAIT_MIX} state_t;

  state_t                  state_q;
  logic [data_width-1:0]   sample_q;
  logic [1:0]              sw_q;
  logic [1:0]              done_q;
  logic [TW-1:0]           timer_q;
  logic                    start0_q, start1_q, dv_q, busy_q, overrun_q;
  logic [cnt_width-1:0]    drop_q, timeout_q;

  logic [1:0] done_seen;
  logic       timer_expired;
  logic       overrun_evt;
  logic       drop_evt;
  logic       timeout_evt;

  assign done_seen     = done_q | {i_done_eff1, i_done_eff0};
  assign timer_expired = (timer_q == TLAST);
  assign overrun_evt   = i_sample_valid && (state_q != IDLE);
  assign drop_evt      = overrun_evt || (i_sample_valid && i_fifo_full);
  assign timeout_evt   = timer_expired &&
                         (((state_q == WAIT_EFF) && !(&done_seen)) ||
                          ((state_q == WAIT_MIX) && !i_mixer_read_done));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      sample_q <= '0;
      sw_q     <= '0;
      done_q   <= '0;
      timer_q  <= '0;
      start0_q <= 1'b0;
      start1_q <= 1'b0;
      dv_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      start0_q <= 1'b0;
      start1_q <= 1'b0;
      dv_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_sample_valid && !i_fifo_full) begin
            sample_q <= i_sample;
            sw_q     <= i_sw;
            start0_q <= i_sw[0];
            start1_q <= i_sw[1];
            busy_q   <= 1'b1;
            state_q  <= DISPATCH;
          end
        end
        DISPATCH: begin
          // Disabled channels will never answer, so count them as already done.
          done_q  <= ~sw_q;
          timer_q <= '0;
          state_q <= WAIT_EFF;
        end
        WAIT_EFF: begin
          done_q <= done_seen;
          if ((&done_seen) || timer_expired) begin
            state_q <= HANDOFF;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        HANDOFF: begin
          if (i_mixer_ready) begin
            dv_q    <= 1'b1;
            timer_q <= '0;
            state_q <= WAIT_MIX;
          end
        end
        WAIT_MIX: begin
          if (i_mixer_read_done || timer_expired) begin
            done_q  <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Statistics: a clear in the same cycle as an event leaves the counters at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_q    <= '0;
      timeout_q <= '0;
      overrun_q <= 1'b0;
    end else if (i_clear_stats) begin
      drop_q    <= '0;
      timeout_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (drop_evt && (drop_q != CMAX)) begin
        drop_q <= drop_q + 1'b1;
      end
      if (timeout_evt && (timeout_q != CMAX)) begin
        timeout_q <= timeout_q + 1'b1;
      end
      if (overrun_evt) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign o_sample_to_eff = sample_q;
  assign o_sw_to_mixer   = sw_q;
  assign o_start_eff0    = start0_q;
  assign o_start_eff1    = start1_q;
  assign o_dv_to_mixer   = dv_q;
  assign o_busy          = busy_q;
  assign o_overrun       = overrun_q;
  assign o_drop_count    = drop_q;
  assign o_timeout_count = timeout_q;

endmodule
